// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generation and load-use stall detection for the ID->EX->MEM->WB core.
// Latency: fwd_sel_* registered (valid while the consumer sits in EX); hazard_stall combinational.
// Backpressure: ext_stall freezes all state; flush/hazard_stall inject an EX bubble. Option macro: FWD_ZERO_REG_EN.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic              id_use_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              hazard_stall
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_v;
    logic              ex_ld;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_v;
    logic [REG_AW-1:0] mem_dst;

    logic src_ok_a;
    logic src_ok_b;

`ifdef FWD_ZERO_REG_EN
    // r0 reads as constant zero, so it never has a producer to forward from.
    assign src_ok_a = (id_src_a != '0);
    assign src_ok_b = (id_src_b != '0);
`else
    assign src_ok_a = 1'b1;
    assign src_ok_b = 1'b1;
`endif

    logic match_a_ex;
    logic match_a_mem;
    logic match_b_ex;
    logic match_b_mem;

    assign match_a_ex  = id_use_a & src_ok_a & ex_v  & (id_src_a == ex_dst);
    assign match_a_mem = id_use_a & src_ok_a & mem_v & (id_src_a == mem_dst);
    assign match_b_ex  = id_use_b & src_ok_b & ex_v  & (id_src_b == ex_dst);
    assign match_b_mem = id_use_b & src_ok_b & mem_v & (id_src_b == mem_dst);

    assign hazard_stall = id_valid & ex_ld & (match_a_ex | match_b_ex) & ~flush;

    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;

    // Youngest producer (EX) wins over the older one in MEM.
    always_comb begin
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
        if (match_a_ex)
            sel_a_nxt = SEL_EX;
        else if (match_a_mem)
            sel_a_nxt = SEL_MEM;
        if (match_b_ex)
            sel_b_nxt = SEL_EX;
        else if (match_b_mem)
            sel_b_nxt = SEL_MEM;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_v      <= 1'b0;
            ex_ld     <= 1'b0;
            ex_dst    <= '0;
            mem_v     <= 1'b0;
            mem_dst   <= '0;
            fwd_sel_a <= SEL_RF;
            fwd_sel_b <= SEL_RF;
        end else if (!ext_stall) begin
            mem_v   <= ex_v;
            mem_dst <= ex_dst;
            if (flush || hazard_stall) begin
                ex_v      <= 1'b0;
                ex_ld     <= 1'b0;
                fwd_sel_a <= SEL_RF;
                fwd_sel_b <= SEL_RF;
            end else begin
                ex_v      <= id_valid & id_wr_en;
                ex_ld     <= id_valid & id_is_load;
                ex_dst    <= id_dst;
                fwd_sel_a <= sel_a_nxt;
                fwd_sel_b <= sel_b_nxt;
            end
        end
    end

endmodule
